// File: rtl/sprite_animator.sv
// Sprite animation and rendering engine: frame sequencing, screen-to-sprite mapping,
// ROM read and tint/transparency stage. Optional SPRITE_ANIM_VSYNC_EN latches ROM state/frame at pixel 0.
module sprite_animator #(
  parameter int unsigned SCREEN_W    = 96,
  parameter int unsigned SCREEN_H    = 64,
  parameter int unsigned PIX_W       = 13,
  parameter int unsigned NUM_STATES  = 8,
  parameter int unsigned MAX_FRAMES  = 4,
  parameter int unsigned TICK_DIV    = 4_500_000,
  parameter logic [15:0] TRANSPARENT = 16'hFFFF,
  localparam int unsigned SW = $clog2(NUM_STATES),
  localparam int unsigned FW = $clog2(MAX_FRAMES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic [6:0]       pos_x,
  input  logic [6:0]       pos_y,
  input  logic             mirror,
  input  logic [1:0]       tint,
  input  logic [SW-1:0]    anim_state,
  input  logic [FW:0]      anim_len,
  input  logic             anim_loop,
  output logic             rom_en,
  output logic [SW-1:0]    rom_state,
  output logic [FW-1:0]    rom_frame,
  output logic [PIX_W-1:0] rom_addr,
  input  logic [15:0]      rom_colour,
  output logic             colour_valid,
  output logic [15:0]      colour,
  output logic             opaque,
  output logic [FW-1:0]    frame_idx,
  output logic             anim_done
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned XW = PIX_W + 1;
  localparam logic [CW-1:0]        TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [FW-1:0]        FRAME_MAX  = FW'(MAX_FRAMES - 1);
  localparam logic [PIX_W-1:0]     SCR_W_U    = PIX_W'(SCREEN_W);
  localparam logic signed [XW-1:0] CANVAS_W   = XW'(SCREEN_W);
  localparam logic signed [XW-1:0] CANVAS_H   = XW'(SCREEN_H);
  localparam logic signed [XW-1:0] HALF_W     = XW'(SCREEN_W / 2);
  localparam logic signed [XW-1:0] HALF_H     = XW'(SCREEN_H / 2);

  // Animation sequencer
  logic [CW-1:0] tick_cnt_q;
  logic [SW-1:0] prev_state_q;
  logic [FW-1:0] frame_q;
  logic          done_fired_q;
  logic          state_chg, tick, at_end;
  logic [FW:0]   len_eff, last_frame;
  logic [FW-1:0] cur_frame;

  always_comb begin
    state_chg  = (anim_state != prev_state_q);
    tick       = (tick_cnt_q == TICK_LAST);
    len_eff    = (anim_len == '0) ? {{FW{1'b0}}, 1'b1} : anim_len;
    last_frame = len_eff - 1'b1;
    // Also stop at the last storable frame so an oversized anim_len cannot wrap the index.
    at_end     = ({1'b0, frame_q} >= last_frame) || (frame_q == FRAME_MAX);
    cur_frame  = state_chg ? '0 : frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      prev_state_q <= '0;
      frame_q      <= '0;
      done_fired_q <= 1'b0;
      anim_done    <= 1'b0;
    end else begin
      prev_state_q <= anim_state;
      anim_done    <= 1'b0;
      if (state_chg) begin
        tick_cnt_q   <= '0;
        frame_q      <= '0;
        done_fired_q <= 1'b0;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        if (tick) begin
          if (!at_end) begin
            frame_q      <= frame_q + 1'b1;
            done_fired_q <= 1'b0;
          end else if (anim_loop) begin
            frame_q <= '0;
          end else if (!done_fired_q) begin
            anim_done    <= 1'b1;
            done_fired_q <= 1'b1;
          end
        end
      end
    end
  end

  assign frame_idx = frame_q;

  // ROM state/frame select
  logic [SW-1:0] rd_state;
  logic [FW-1:0] rd_frame;

`ifdef SPRITE_ANIM_VSYNC_EN
  logic [SW-1:0] disp_state_q;
  logic [FW-1:0] disp_frame_q;
  logic          vsync_load;

  always_comb begin
    vsync_load = pix_valid && (pixel_index == '0);
    rd_state   = vsync_load ? anim_state : disp_state_q;
    rd_frame   = vsync_load ? cur_frame  : disp_frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_state_q <= '0;
      disp_frame_q <= '0;
    end else if (vsync_load) begin
      disp_state_q <= anim_state;
      disp_frame_q <= cur_frame;
    end
  end
`else
  always_comb begin
    rd_state = anim_state;
    rd_frame = cur_frame;
  end
`endif

  // Screen to sprite-local mapping
  logic [PIX_W-1:0]        col_u, row_u;
  logic signed [XW-1:0]    col_s, row_s, px_s, py_s, lx, ly, addr_s;
  logic                    in_bounds;

  always_comb begin
    col_u     = pixel_index % SCR_W_U;
    row_u     = pixel_index / SCR_W_U;
    col_s     = $signed({1'b0, col_u});
    row_s     = $signed({1'b0, row_u});
    px_s      = $signed({{(XW-7){1'b0}}, pos_x});
    py_s      = $signed({{(XW-7){1'b0}}, pos_y});
    lx        = mirror ? (px_s + HALF_W - col_s) : (col_s - px_s + HALF_W);
    ly        = row_s - py_s + HALF_H;
    in_bounds = !lx[XW-1] && (lx < CANVAS_W) && !ly[XW-1] && (ly < CANVAS_H);
    addr_s    = ly * CANVAS_W + lx;
  end

  // Stage 1: ROM request; stage 2 side-band tracks the ROM data register
  logic       v1_q, inb1_q, v2_q, inb2_q;
  logic [1:0] tint1_q, tint2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en    <= 1'b0;
      rom_state <= '0;
      rom_frame <= '0;
      rom_addr  <= '0;
      v1_q      <= 1'b0;
      inb1_q    <= 1'b0;
      tint1_q   <= '0;
      v2_q      <= 1'b0;
      inb2_q    <= 1'b0;
      tint2_q   <= '0;
    end else begin
      rom_en    <= pix_valid && in_bounds;
      rom_state <= rd_state;
      rom_frame <= rd_frame;
      rom_addr  <= addr_s[PIX_W-1:0];
      v1_q      <= pix_valid;
      inb1_q    <= in_bounds;
      tint1_q   <= tint;
      v2_q      <= v1_q;
      inb2_q    <= inb1_q;
      tint2_q   <= tint1_q;
    end
  end

  // Stage 3: transparency key and tint
  logic [15:0] tinted;

  always_comb begin
    tinted = rom_colour;
    unique case (tint2_q)
      2'd1:    tinted = {rom_colour[15:11], 1'b0, rom_colour[10:6], rom_colour[4:0]};
      2'd2:    tinted = {1'b0, rom_colour[15:12], rom_colour[10:0]};
      2'd3:    tinted = {rom_colour[15:5], 1'b0, rom_colour[4:1]};
      default: tinted = rom_colour;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_valid <= 1'b0;
      colour       <= TRANSPARENT;
      opaque       <= 1'b0;
    end else begin
      colour_valid <= v2_q;
      if (v2_q && inb2_q && (rom_colour != TRANSPARENT)) begin
        colour <= tinted;
        opaque <= 1'b1;
      end else begin
        colour <= TRANSPARENT;
        opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Scoreboarded bench for sprite_animator: reset, animation sequencing, mapping, tint, streaming.
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [12:0] pixel_index;
  logic [6:0]  pos_x, pos_y;
  logic        mirror;
  logic [1:0]  tint;
  logic [2:0]  anim_state;
  logic [2:0]  anim_len;
  logic        anim_loop;
  logic        rom_en;
  logic [2:0]  rom_state;
  logic [1:0]  rom_frame;
  logic [12:0] rom_addr;
  logic [15:0] rom_colour;
  logic        colour_valid;
  logic [15:0] colour;
  logic        opaque;
  logic [1:0]  frame_idx;
  logic        anim_done;

  int checks = 0;
  int failures = 0;
  int rom_mode = 0;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  sprite_animator #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pixel_index(pixel_index),
    .pos_x(pos_x), .pos_y(pos_y), .mirror(mirror), .tint(tint),
    .anim_state(anim_state), .anim_len(anim_len), .anim_loop(anim_loop),
    .rom_en(rom_en), .rom_state(rom_state), .rom_frame(rom_frame), .rom_addr(rom_addr),
    .rom_colour(rom_colour), .colour_valid(colour_valid), .colour(colour),
    .opaque(opaque), .frame_idx(frame_idx), .anim_done(anim_done)
  );

  function automatic logic [15:0] rom_fn(input int addr);
    case (rom_mode)
      0:       return 16'(addr * 7 + 'h1234);
      1:       return 16'h07E0;
      2:       return 16'hFFFF;
      default: return 16'hF81F;
    endcase
  endfunction

  // Synchronous ROM model: data one cycle after the strobe
  always @(posedge clk) if (rom_en) rom_colour <= rom_fn(int'(rom_addr));

  task automatic map_model(input int idx, input bit mir, input int px, input int py,
                           output bit inb, output int addr);
    int col, row, lx, ly;
    col  = idx % 96;
    row  = idx / 96;
    lx   = mir ? (px + 48 - col) : (col - px + 48);
    ly   = row - py + 32;
    inb  = (lx >= 0) && (lx < 96) && (ly >= 0) && (ly < 64);
    addr = ly * 96 + lx;
  endtask

  function automatic logic [16:0] exp_out(input bit inb, input int addr, input int t);
    logic [15:0] rc, r, g, b;
    if (!inb) return {1'b0, 16'hFFFF};
    rc = rom_fn(addr);
    if (rc == 16'hFFFF) return {1'b0, 16'hFFFF};
    r = rc & 16'hF800;
    g = rc & 16'h07E0;
    b = rc & 16'h001F;
    case (t)
      1: g = (g >> 1) & 16'h07E0;
      2: r = (r >> 1) & 16'hF800;
      3: b = (b >> 1) & 16'h001F;
      default: ;
    endcase
    return {1'b1, r | g | b};
  endfunction

  // One pipeline cycle: drive a pixel, predict, then check stage-1 and stage-3 outputs.
  task automatic step(input bit v, input int idx, input bit mir, input int px, input int py,
                      input int t);
    bit inb;
    int addr;
    logic [16:0] e;
    pix_valid   = v;
    pixel_index = idx[12:0];
    mirror      = mir;
    pos_x       = px[6:0];
    pos_y       = py[6:0];
    tint        = t[1:0];
    map_model(idx, mir, px, py, inb, addr);
    if (v) q.push_back(exp_out(inb, addr, t));
    @(posedge clk); #1;
    checks++;
    if (rom_en !== (v && inb)) begin
      failures++;
      $display("FAIL rom_en idx=%0d got=%b exp=%b", idx, rom_en, v && inb);
    end
    if (v && inb) begin
      checks++;
      if (rom_addr !== addr[12:0]) begin
        failures++;
        $display("FAIL rom_addr idx=%0d got=%0d exp=%0d", idx, rom_addr, addr);
      end
    end
    if (colour_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_valid got colour=%h exp=no output", colour);
      end else begin
        e = q.pop_front();
        if ({opaque, colour} !== e) begin
          failures++;
          $display("FAIL pixel_out got=%b/%h exp=%b/%h", opaque, colour, e[16], e[15:0]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 48, 32, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rst_n = 1'b0; pix_valid = 1'b1; pixel_index = 13'd3122; pos_x = 7'd48; pos_y = 7'd32;
    mirror = 1'b0; tint = 2'd0; anim_state = '0; anim_len = 3'd1; anim_loop = 1'b1;
    rom_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (colour !== 16'hFFFF) begin failures++; $display("FAIL rst_colour got=%h exp=ffff", colour); end
    checks++;
    if (colour_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", colour_valid); end
    checks++;
    if (frame_idx !== 2'd0) begin failures++; $display("FAIL rst_frame got=%0d exp=0", frame_idx); end
    checks++;
    if ({rom_en, opaque, anim_done} !== 3'b000) begin
      failures++;
      $display("FAIL rst_outs got=%b exp=000", {rom_en, opaque, anim_done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (colour_valid !== 1'b0) begin failures++; $display("FAIL lat_e0 got=%b exp=0", colour_valid); end
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (colour_valid !== 1'b0) begin failures++; $display("FAIL lat_e1 got=%b exp=0", colour_valid); end
    @(posedge clk); #1;
    e = exp_out(1'b1, 3122, 0);
    checks++;
    if (colour_valid !== 1'b1 || {opaque, colour} !== e) begin
      failures++;
      $display("FAIL lat_e2 got=%b %b/%h exp=1 %b/%h", colour_valid, opaque, colour, e[16], e[15:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_loop();
    int f, rf;
    pix_valid = 1'b0;
    anim_len = 3'd3; anim_loop = 1'b1; anim_state = 3'd1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      f  = (k / 4) % 3;
      rf = (k == 0) ? 0 : ((k - 1) / 4) % 3;
      checks++;
      if (frame_idx !== f[1:0]) begin
        failures++;
        $display("FAIL loop_frame k=%0d got=%0d exp=%0d", k, frame_idx, f);
      end
      checks++;
      if (anim_done !== 1'b0) begin failures++; $display("FAIL loop_done k=%0d got=1 exp=0", k); end
`ifndef SPRITE_ANIM_VSYNC_EN
      checks++;
      if (rom_frame !== rf[1:0] || rom_state !== 3'd1) begin
        failures++;
        $display("FAIL loop_rom k=%0d got=%0d/%0d exp=1/%0d", k, rom_state, rom_frame, rf);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_oneshot();
    int f;
    anim_len = 3'd2; anim_loop = 1'b0; anim_state = 3'd2;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      f = (k < 4) ? 0 : (k < 12) ? 1 : (k < 18) ? 0 : 1;
      checks++;
      if (frame_idx !== f[1:0]) begin
        failures++;
        $display("FAIL oneshot_frame k=%0d got=%0d exp=%0d", k, frame_idx, f);
      end
      checks++;
      if (anim_done !== (k == 8)) begin
        failures++;
        $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, anim_done, k == 8);
      end
      @(negedge clk);
      if (k == 11) anim_state = 3'd3;  // change coincides with a tick
      if (k == 13) anim_state = 3'd4;  // change mid-period restarts the counter
    end
  endtask

  task automatic test_mapping();
    rom_mode = 0;
    step(1'b1, 3122, 1'b0, 48, 32, 0);
    step(1'b1, 3122, 1'b1, 48, 32, 0);
    step(1'b1, 3152, 1'b0, 10, 32, 0);
    step(1'b1, 3072, 1'b0, 48, 32, 0);
    step(1'b1, 3072, 1'b0, 49, 32, 0);
    step(1'b1, 3119, 1'b0, 0, 32, 0);
    step(1'b1, 3120, 1'b0, 0, 32, 0);
    step(1'b1, 2976, 1'b0, 48, 0, 0);
    step(1'b1, 3072, 1'b0, 48, 0, 0);
    step(1'b1, 2880, 1'b0, 48, 63, 0);
    step(1'b1, 2976, 1'b0, 48, 63, 0);
    flush();
  endtask

  task automatic test_tint();
    rom_mode = 1;
    step(1'b1, 3122, 1'b0, 48, 32, 1);
    step(1'b1, 3123, 1'b0, 48, 32, 0);
    flush();
    rom_mode = 3;
    step(1'b1, 3122, 1'b0, 48, 32, 2);
    step(1'b1, 3122, 1'b0, 48, 32, 3);
    flush();
    rom_mode = 2;
    step(1'b1, 3122, 1'b0, 48, 32, 1);
    flush();
    rom_mode = 0;
    step(1'b1, 100, 1'b0, 40, 30, 2);
    step(1'b1, 200, 1'b1, 40, 30, 3);
    flush();
  endtask

  task automatic test_back_to_back();
    rom_mode = 0;
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 6143), 1'($urandom_range(0, 1)),
           $urandom_range(20, 76), $urandom_range(10, 54), $urandom_range(0, 3));
    flush();
  endtask

  task automatic test_reset_midstream();
    rom_mode = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 3100 + i, 1'b0, 48, 32, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({colour_valid, rom_en, opaque} !== 3'b000 || colour !== 16'hFFFF) begin
      failures++;
      $display("FAIL midrst got=%b/%h exp=000/ffff", {colour_valid, rom_en, opaque}, colour);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    for (int i = 0; i < 3; i++) step(1'b1, 3000 + i, 1'b0, 48, 32, 1);
    flush();
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_mapping();
    test_tint();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
